tdm_mux_8_1: RTL and testbench

//   Time-division 8:1 multiplexer; transmit end of the 1:8 demux path.

---
 rtl/tdm_mux_8_1.sv | 134 +++++++++++++
 tb/tb_tdm_mux_8_1.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_8_1.sv
// ---------------------------------------------------------------------------
// tdm_mux_8_1
//   Time-division 8:1 multiplexer, the transmit end of a 1:8 demux link.
//   One load handshake captures eight channel words. They are then sent on a
//   single lane, channel 0 first, with each channel holding the lane for
//   SLOT_CYCLES enabled clock cycles. Select_Out drives the far-end demux
//   select. Frame_Start_Out and Frame_Done_Out mark the frame boundaries.
//   A new frame can be accepted in the last cycle of the current frame, so
//   back-to-back frames leave no gap on the lane.
//
// Ports
//   Clock_In         in   1             rising-edge clock
//   Reset_n_In       in   1             asynchronous reset, active-low
//   Enable_In        in   1             0 = pause (counters and state hold)
//   Load_Valid_In    in   1             Channel_Data_In holds a frame
//   Load_Ready_Out   out  1             a frame is accepted this cycle if valid
//   Channel_Data_In  in   8*DATA_WIDTH  ch k = [k*DATA_WIDTH +: DATA_WIDTH]
//   MUX_Data_Out     out  DATA_WIDTH    current channel word
//   Select_Out       out  3             channel index on MUX_Data_Out
//   Data_Valid_Out   out  1             MUX_Data_Out/Select_Out valid
//   Frame_Start_Out  out  1             first cycle of slot 0
//   Frame_Done_Out   out  1             last cycle of slot 7
// ---------------------------------------------------------------------------
module tdm_mux_8_1 #(
    parameter int DATA_WIDTH  = 1,
    parameter int SLOT_CYCLES = 1
) (
    input  logic                    Clock_In,
    input  logic                    Reset_n_In,
    input  logic                    Enable_In,
    input  logic                    Load_Valid_In,
    output logic                    Load_Ready_Out,
    input  logic [8*DATA_WIDTH-1:0] Channel_Data_In,
    output logic [DATA_WIDTH-1:0]   MUX_Data_Out,
    output logic [2:0]              Select_Out,
    output logic                    Data_Valid_Out,
    output logic                    Frame_Start_Out,
    output logic                    Frame_Done_Out
);

    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  r_state;
    logic [8*DATA_WIDTH-1:0] r_buffer;
    logic [2:0]              r_slot;
    logic [CYC_W-1:0]        r_cyc;
    logic [DATA_WIDTH-1:0]   r_mux_data;
    logic [2:0]              r_select;

    logic                    w_slot_end;
    logic                    w_last;
    logic                    w_accept;
    logic [2:0]              w_slot_inc;
    logic [DATA_WIDTH-1:0]   w_next_word;

    // Handshake and frame markers are decoded straight from the registered
    // state so they line up with the cycle they describe.
    assign w_slot_end  = (r_cyc == CYC_LAST);
    assign w_last      = Enable_In && (r_state == SEND) && (r_slot == 3'd7) && w_slot_end;
    assign w_accept    = Load_Valid_In && Load_Ready_Out;
    assign w_slot_inc  = r_slot + 3'd1;
    assign w_next_word = r_buffer[32'(w_slot_inc) * DATA_WIDTH +: DATA_WIDTH];

    assign Load_Ready_Out  = Enable_In && ((r_state == IDLE) || w_last);
    assign Frame_Start_Out = Enable_In && (r_state == SEND) && (r_slot == 3'd0)
                             && (r_cyc == '0);
    assign Frame_Done_Out  = w_last;

    // Valid is gated by Enable_In so it drops in the paused cycle itself,
    // together with the frame markers; the data and select registers hold.
    assign Data_Valid_Out  = Enable_In && (r_state == SEND);
    assign MUX_Data_Out    = r_mux_data;
    assign Select_Out      = r_select;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking would make the order of the
    // statements change the hardware.
    // NOTE: the frame buffer is reset too, because a cleared buffer is part
    // of the defined reset state rather than a don't-care storage array.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_state    <= IDLE;
            r_buffer   <= '0;
            r_slot     <= 3'd0;
            r_cyc      <= '0;
            r_mux_data <= '0;
            r_select   <= 3'd0;
        end else if (Enable_In) begin
            if (w_accept) begin
                // Covers both the IDLE load and the gapless reload in the
                // last cycle of a frame.
                r_state    <= SEND;
                r_buffer   <= Channel_Data_In;
                r_slot     <= 3'd0;
                r_cyc      <= '0;
                r_mux_data <= Channel_Data_In[DATA_WIDTH-1:0];
                r_select   <= 3'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_mux_data <= '0;
                        r_select   <= 3'd0;
                    end
                    SEND: begin
                        if (w_last) begin
                            r_state    <= IDLE;
                            r_slot     <= 3'd0;
                            r_cyc      <= '0;
                            r_mux_data <= '0;
                            r_select   <= 3'd0;
                        end else if (w_slot_end) begin
                            r_cyc      <= '0;
                            r_slot     <= w_slot_inc;
                            r_mux_data <= w_next_word;
                            r_select   <= w_slot_inc;
                        end else begin
                            r_cyc      <= r_cyc + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// ---------------------------------------------------------------------------
// tb_tdm_mux_8_1
//   Directed bench for tdm_mux_8_1. Two instances share clock, reset, enable
//   and channel data: u_dut1 with SLOT_CYCLES=1 and u_dut2 with SLOT_CYCLES=2,
//   each with its own load-valid. Inputs change on the falling edge and
//   outputs are checked shortly after, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_tdm_mux_8_1;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       valid1;
    logic       valid2;

    logic       ready1, dv1, fs1, fd1;
    logic [0:0] mux1;
    logic [2:0] sel1;
    logic       ready2, dv2, fs2, fd2;
    logic [0:0] mux2;
    logic [2:0] sel2;

    int checks   = 0;
    int failures = 0;

    tdm_mux_8_1 #(.DATA_WIDTH(1), .SLOT_CYCLES(1)) u_dut1 (
        .Clock_In        (clk),
        .Reset_n_In      (rst_n),
        .Enable_In       (en),
        .Load_Valid_In   (valid1),
        .Load_Ready_Out  (ready1),
        .Channel_Data_In (data),
        .MUX_Data_Out    (mux1),
        .Select_Out      (sel1),
        .Data_Valid_Out  (dv1),
        .Frame_Start_Out (fs1),
        .Frame_Done_Out  (fd1)
    );

    tdm_mux_8_1 #(.DATA_WIDTH(1), .SLOT_CYCLES(2)) u_dut2 (
        .Clock_In        (clk),
        .Reset_n_In      (rst_n),
        .Enable_In       (en),
        .Load_Valid_In   (valid2),
        .Load_Ready_Out  (ready2),
        .Channel_Data_In (data),
        .MUX_Data_Out    (mux2),
        .Select_Out      (sel2),
        .Data_Valid_Out  (dv2),
        .Frame_Start_Out (fs2),
        .Frame_Done_Out  (fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One clock: through the rising edge to the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full expected picture of u_dut2 in one cycle.
    task automatic check_dut2(input string tag, input logic dv, input logic [2:0] sel,
                              input logic mux, input logic fs, input logic fd,
                              input logic rdy);
        #1;
        check({tag, ".dv"},    32'(dv2),    32'(dv));
        check({tag, ".sel"},   32'(sel2),   32'(sel));
        check({tag, ".mux"},   32'(mux2),   32'(mux));
        check({tag, ".fs"},    32'(fs2),    32'(fs));
        check({tag, ".fd"},    32'(fd2),    32'(fd));
        check({tag, ".ready"}, 32'(ready2), 32'(rdy));
    endtask

    // Expected lane sequence for 8'b1010_0110, channel 0 first.
    logic       exp_seq [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] frame_a = 8'hC3;
    logic [7:0] frame_b = 8'h3C;
    logic [7:0] frame_p = 8'h5A;
    logic [7:0] cur;
    int         s_idx;

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        data   = 8'h00;
        valid1 = 1'b0;
        valid2 = 1'b0;

        // ---- 1: reset then idle ----
        repeat (2) @(negedge clk);
        #1;
        check("rst.dv",    32'(dv1),    32'd0);
        check("rst.mux",   32'(mux1),   32'd0);
        check("rst.sel",   32'(sel1),   32'd0);
        check("rst.fs",    32'(fs1),    32'd0);
        check("rst.fd",    32'(fd1),    32'd0);
        check("rst.ready", 32'(ready1), 32'd1);
        rst_n = 1'b1;
        step();
        #1;
        check("idle.dv",    32'(dv1),    32'd0);
        check("idle.ready", 32'(ready1), 32'd1);
        check("idle.mux",   32'(mux1),   32'd0);

        // ---- 2 + 6: single frame, SLOT_CYCLES=1, sample isolation ----
        @(negedge clk);
        data   = 8'b1010_0110;
        valid1 = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            // Garbage data and a pending valid during the frame; only the
            // final cycle is ready, so drop valid there to end in IDLE.
            data   = 8'hFF ^ 8'(i);
            valid1 = (i < 7);
            #1;
            check($sformatf("f1.dv%0d", i),    32'(dv1),    32'd1);
            check($sformatf("f1.sel%0d", i),   32'(sel1),   32'(i));
            check($sformatf("f1.mux%0d", i),   32'(mux1),   32'(exp_seq[i]));
            check($sformatf("f1.fs%0d", i),    32'(fs1),    32'(i == 0));
            check($sformatf("f1.fd%0d", i),    32'(fd1),    32'(i == 7));
            check($sformatf("f1.ready%0d", i), 32'(ready1), 32'(i == 7));
            step();
        end
        #1;
        check("f1.end.dv",    32'(dv1),    32'd0);
        check("f1.end.mux",   32'(mux1),   32'd0);
        check("f1.end.sel",   32'(sel1),   32'd0);
        check("f1.end.ready", 32'(ready1), 32'd1);
        step();
        check("f1.noacc.dv", 32'(dv1), 32'd0);

        // ---- 3: back-to-back frames, SLOT_CYCLES=2, valid held ----
        data   = frame_a;
        valid2 = 1'b1;
        #1;
        check("b2b.ready0", 32'(ready2), 32'd1);
        step();
        for (int f = 0; f < 2; f++) begin
            cur = (f == 0) ? frame_a : frame_b;
            for (int s = 0; s < 16; s++) begin
                if (f == 0 && s == 0) data = frame_b;
                if (f == 1 && s == 0) begin
                    valid2 = 1'b0;
                    data   = 8'hFF;
                end
                check_dut2($sformatf("b2b.f%0d.c%0d", f, s), 1'b1, 3'(s / 2),
                           cur[s / 2], s == 0, s == 15, s == 15);
                step();
            end
        end
        check_dut2("b2b.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---- 4: pause during slot 4 ----
        data   = frame_p;
        valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        data   = 8'h00;
        s_idx  = 0;
        for (int c = 0; c < 19; c++) begin
            if (c >= 9 && c < 12) begin
                en = 1'b0;
                check_dut2($sformatf("pause.c%0d", c), 1'b0, 3'd4, frame_p[4],
                           1'b0, 1'b0, 1'b0);
            end else begin
                en = 1'b1;
                check_dut2($sformatf("pause.c%0d", c), 1'b1, 3'(s_idx / 2),
                           frame_p[s_idx / 2], s_idx == 0, s_idx == 15, s_idx == 15);
                s_idx++;
            end
            step();
        end
        en = 1'b1;
        check_dut2("pause.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---- 5: reset mid-frame ----
        data   = 8'hFF;
        valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        repeat (6) step();
        check_dut2("mrst.pre", 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst.dv",  32'(dv2),  32'd0);
        check("mrst.sel", 32'(sel2), 32'd0);
        check("mrst.mux", 32'(mux2), 32'd0);
        check("mrst.fs",  32'(fs2),  32'd0);
        check("mrst.fd",  32'(fd2),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            #1;
            check($sformatf("mrst.after%0d", c), 32'(dv2), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
